// File: rtl/huffman_pkg.sv
// Shared Huffman code table, widths and encoder state encoding.
// Optional statistics outputs are enabled with HUFFMAN_ENC_STATS_EN.
package huffman_pkg;

  localparam int WORD_W = 6;
  localparam int ACC_W  = 11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_EMIT  = 2'd1,
    ST_FLUSH = 2'd2
  } enc_state_t;

  // Entries run from symbol 15 (leftmost) down to symbol 0; codes are right-aligned.
  localparam logic [15:0][5:0] CODE_TAB = {
    6'b000101, 6'b000100, 6'b000000, 6'b000111,
    6'b000000, 6'b000000, 6'b000111, 6'b000110,
    6'b001101, 6'b000011, 6'b000010, 6'b011001,
    6'b011000, 6'b000101, 6'b000100, 6'b000001
  };

  localparam logic [15:0][2:0] LEN_TAB = {
    3'd6, 3'd6, 3'd0, 3'd6,
    3'd0, 3'd4, 3'd4, 3'd6,
    3'd5, 3'd4, 3'd4, 3'd6,
    3'd6, 3'd4, 3'd4, 3'd1
  };

  localparam logic [15:0] ILLEGAL_MASK = 16'h2800;

endpackage

// File: rtl/huffman_code_lut.sv
// Combinational symbol to {right-aligned code, length, illegal} lookup.
module huffman_code_lut
  import huffman_pkg::*;
(
  input  logic [3:0] symbol,
  output logic [5:0] code,
  output logic [2:0] len,
  output logic       illegal
);

  always_comb begin
    code    = CODE_TAB[symbol];
    len     = LEN_TAB[symbol];
    illegal = ILLEGAL_MASK[symbol];
  end

endmodule

// File: rtl/huffman_encoder.sv
// Packs Huffman codes MSB-first into 6-bit words with flush of residual bits.
// Define HUFFMAN_ENC_STATS_EN to add sym_count/bit_count statistics outputs.
module huffman_encoder
  import huffman_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        symbol_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] encodedData,
  output logic              load,
  input  logic              out_ready,
  output logic [2:0]        out_bits,
  output logic              flush_done,
  output logic              sym_err
`ifdef HUFFMAN_ENC_STATS_EN
  ,
  output logic [15:0]       sym_count,
  output logic [19:0]       bit_count
`endif
);

  enc_state_t       state, state_n;
  logic [ACC_W-1:0] acc, acc_n, placed;
  logic [3:0]       cnt, cnt_n, shamt;
  logic             flush_pend, pend_n;
  logic             done_n, err_n, accept;
  logic [5:0]       lut_code;
  logic [2:0]       lut_len;
  logic             lut_illegal;

  huffman_code_lut u_lut (
    .symbol  (symbol_in),
    .code    (lut_code),
    .len     (lut_len),
    .illegal (lut_illegal)
  );

  assign accept = sym_valid && sym_ready;
  // cnt <= 5 in RUN and len <= 6, so the shift never goes negative.
  assign shamt  = 4'(ACC_W) - cnt - {1'b0, lut_len};
  assign placed = {5'b0, lut_code} << shamt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      sym_err    <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      flush_pend <= pend_n;
      flush_done <= done_n;
      sym_err    <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    pend_n  = flush_pend | flush;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept) begin
          if (lut_illegal) begin
            err_n = 1'b1;
          end else begin
            acc_n = acc | placed;
            cnt_n = cnt + {1'b0, lut_len};
          end
        end
        // A full word always drains before any pending flush is honoured.
        if (cnt_n >= 4'd6) begin
          state_n = ST_EMIT;
        end else if (pend_n) begin
          if (cnt_n == 4'd0) begin
            pend_n = 1'b0;
            done_n = 1'b1;
          end else begin
            state_n = ST_FLUSH;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          acc_n   = acc << WORD_W;
          cnt_n   = cnt - 4'd6;
          state_n = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (out_ready) begin
          acc_n   = '0;
          cnt_n   = '0;
          pend_n  = 1'b0;
          done_n  = 1'b1;
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_comb begin
    load        = (state == ST_EMIT) || (state == ST_FLUSH);
    sym_ready   = rst && (state == ST_RUN) && (cnt < 4'd6);
    encodedData = load ? acc[ACC_W-1 -: WORD_W] : '0;
    out_bits    = 3'd0;
    if (state == ST_EMIT)  out_bits = 3'd6;
    if (state == ST_FLUSH) out_bits = cnt[2:0];
  end

`ifdef HUFFMAN_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_count <= '0;
      bit_count <= '0;
    end else if (state == ST_RUN && accept && !lut_illegal) begin
      sym_count <= sym_count + 16'd1;
      bit_count <= bit_count + {17'd0, lut_len};
    end
  end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: directed symbols, hand-computed words.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] symbol_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       flush;
  logic [5:0] encodedData;
  logic       load;
  logic       out_ready;
  logic [2:0] out_bits;
  logic       flush_done;
  logic       sym_err;
`ifdef HUFFMAN_ENC_STATS_EN
  logic [15:0] sym_count;
  logic [19:0] bit_count;
`endif

  typedef struct packed {
    logic [5:0] data;
    logic [2:0] bits;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  huffman_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .symbol_in   (symbol_in),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .flush       (flush),
    .encodedData (encodedData),
    .load        (load),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .flush_done  (flush_done),
    .sym_err     (sym_err)
`ifdef HUFFMAN_ENC_STATS_EN
    ,
    .sym_count   (sym_count),
    .bit_count   (bit_count)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every accepted output word is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst && load && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got data=%b bits=%0d, none expected", encodedData, out_bits);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (encodedData !== e.data || out_bits !== e.bits) begin
          miscompares++;
          $display("FAIL word: got data=%b bits=%0d, expected data=%b bits=%0d",
                   encodedData, out_bits, e.data, e.bits);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] d, input logic [2:0] b);
    exp_q.push_back({d, b});
  endtask

  task automatic send(input logic [3:0] s);
    int n = 0;
    while (!sym_ready && n < 50) begin
      tick();
      n++;
    end
    if (!sym_ready) chk("sym_ready_timeout", 8'(sym_ready), 8'd1);
    symbol_in = s;
    sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!sym_ready && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_flush();
    wait_ready();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!flush_done && n < 20) begin
      tick();
      n++;
    end
    chk(name, 8'(flush_done), 8'd1);
  endtask

  task automatic run_ones();
    push(6'b111111, 3'd6);
    for (int i = 0; i < 6; i++) send(4'd0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b0; symbol_in = '0; sym_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_load", 8'(load), 8'd0);
    chk("rst_ready", 8'(sym_ready), 8'd0);
    chk("rst_data", 8'(encodedData), 8'd0);
    chk("rst_bits", 8'(out_bits), 8'd0);
    chk("rst_flags", {6'd0, flush_done, sym_err}, 8'd0);
    rst = 1'b1;
    tick();

    // 1: six symbol 0
    run_ones();

    // 2: symbol 3 fills a word alone; load must follow the accept edge
    push(6'b011000, 3'd6);
    send(4'd3);
    chk("t2_latency", 8'(load), 8'd1);
    repeat (2) tick();

    // 3: 9,7 then flush of the 3 residual bits
    push(6'b011101, 3'd6);
    push(6'b101000, 3'd3);
    send(4'd9);
    send(4'd7);
    pulse_flush();
    wait_done("t3_flush_done");
    tick();

    // flush with nothing buffered: done pulse, no word
    pulse_flush();
    chk("empty_flush_done", 8'(flush_done), 8'd1);
    chk("empty_flush_load", 8'(load), 8'd0);

    // 4: illegal symbol, then symbol 0 proves cnt untouched
    send(4'd11);
    chk("t4_sym_err", 8'(sym_err), 8'd1);
    chk("t4_load", 8'(load), 8'd0);
    tick();
    chk("t4_err_pulse", 8'(sym_err), 8'd0);
    push(6'b100000, 3'd1);
    send(4'd0);
    pulse_flush();
    wait_done("t4_flush_done");

    // mixed lengths: 1,2,5,12,14
    push(6'b010001, 3'd6);
    push(6'b010010, 3'd6);
    push(6'b000111, 3'd6);
    push(6'b000100, 3'd6);
    send(4'd1); send(4'd2); send(4'd5); send(4'd12); send(4'd14);
    repeat (3) tick();

    // 5: backpressure during EMIT
    out_ready = 1'b0;
    push(6'b111111, 3'd6);
    for (int i = 0; i < 6; i++) send(4'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_load", 8'(load), 8'd1);
      chk("t5_data", 8'(encodedData), 8'h3f);
      chk("t5_ready", 8'(sym_ready), 8'd0);
      tick();
    end
    out_ready = 1'b1;
    repeat (2) tick();

    // 6: reset in the middle of FLUSH
    out_ready = 1'b0;
    send(4'd9);
    pulse_flush();
    chk("t6_in_flush", {load, 4'd0, out_bits}, {1'b1, 4'd0, 3'd4});
    rst = 1'b0;
    tick();
    chk("t6_load_cleared", 8'(load), 8'd0);
    chk("t6_ready_in_rst", 8'(sym_ready), 8'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    run_ones();

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
